gmii_rx_speed_adapter: RTL and testbench
========================================

Name: gmii_rx_speed_adapter

Overview:
Receive-direction counterpart of the transmit clock-enable/nibble logic in the RGMII PHY interface. It sits on the MAC receive clock, directly after the RGMII DDR input stage.
- At 10/100 it packs one nibble per cycle into bytes, aligning on the SFD, and produces a byte-valid strobe.
- At 1000 it is a registered pass-through.
- It also decodes RGMII in-band link status during inter-frame.

Parameters:
STATUS_FILTER, 2, consecutive identical in-band status samples required before status outputs update (1..15).
ENABLE_INBAND, 1, 0 = status outputs held at reset values.

Ports:
clk  input  1  MAC receive clock (the RGMII RX clock after the input buffer).
rst  input  1  synchronous active-high reset.
speed  input  2  00=10M, 01=100M, 1x=1000M.
gmii_rxd  input  8  from the DDR input stage; only [3:0] is meaningful at 10/100.
gmii_rx_dv  input  1  data valid (first-edge CTL).
gmii_rx_er  input  1  CTL1 xor CTL2.
out_rxd  output  8  assembled byte.
out_rx_dv  output  1  byte belongs to a frame.
out_rx_er  output  1  byte error.
out_clk_en  output  1  qualifies out_* for one cycle.
link_up  output  1  in-band link status.
link_speed  output  2  in-band speed.
full_duplex  output  1  in-band duplex.

Behaviour:
- Reset: all outputs 0; state IDLE; pending nibble cleared; filter counter 0. Reset mid-frame drops the frame silently, with no error strobe.
- 1000M:
  - out_rxd/out_rx_dv/out_rx_er are gmii_* registered once; latency 1.
  - out_clk_en=1 every cycle.
- 10/100 state machine (IDLE, PREAMBLE, DATA):
  - IDLE: on gmii_rx_dv=1 go to PREAMBLE and store nibble as prev. out_clk_en=0.
  - PREAMBLE: each cycle prev<=nibble.
    - If nibble==4'hD and prev==4'h5: emit byte 8'hD5 (dv=1, er=gmii_rx_er) and go to DATA with phase=LOW.
    - No bytes are emitted before the SFD.
    - If dv drops before the SFD: return to IDLE with no output.
  - DATA: phase LOW stores the low nibble; phase HIGH emits {nibble, low}.
    - out_clk_en=1 for exactly one cycle, 1 cycle after the high nibble is sampled.
    - er = OR of gmii_rx_er over both nibbles.
  - Frame end: dv=0 in DATA returns to IDLE.
    - If phase==HIGH (odd nibble count), emit {4'h0, low} with dv=1, er=1.
    - After the last byte, one strobe with out_rx_dv=0, out_rx_er=0 marks end of frame.
- Between strobes, out_* hold their values.
- Speed change: speed registered as speed_q; speed!=speed_q forces IDLE.
  - If it occurs in DATA, emit one strobe with dv=1, er=1, rxd=0, then the end strobe.
  - The pending nibble is discarded.
- In-band status: sampled only when gmii_rx_dv=0 and gmii_rx_er=0.
  - Fields: link=rxd[0], speed=rxd[2:1], duplex=rxd[3].
  - Counter increments while the sample equals the previous sample; otherwise it resets to 1.
  - Outputs update when the count reaches STATUS_FILTER; the counter saturates.
  - Samples with dv=0 and er=1 (false carrier / extension) neither update nor reset the counter.
  - Status decoding is independent of speed.
- Widths: nibble counters do not exist, so frame length is unbounded. The filter counter is 4 bits, saturating.

Decomposition:
- Shared package (rgmii_pkg):
  - SPEED_10=2'b00, SPEED_100=2'b01, SPEED_1000=2'b10.
  - NIB_PREAMBLE=4'h5, NIB_SFD=4'hD.
  - State encoding localparams.
- One sub-module: rgmii_inband_status, containing the filter and the status registers; parameter STATUS_FILTER.

Test Plan:
- 1000M, rxd 8'h55×7, 8'hD5, 8'h01..8'h40 with dv=1 → identical byte stream 1 cycle later; out_clk_en constantly 1.
- 100M, nibbles 5×15, D, then 1,0,2,0 → strobes 8'hD5, 8'h01, 8'h02, then an end strobe with dv=0. No output before the SFD.
- 10M, odd frame: 5,5,D,A,B,C then dv=0 → 8'hD5, 8'hBA, then 8'h0C with er=1, then the end strobe.
- 100M, gmii_rx_er=1 on the high nibble of the 2nd data byte → only that byte has er=1; neighbouring bytes have er=0.
- Idle with rxd=4'b1101 for 1 cycle, then 4'b1101 for 2 cycles, with STATUS_FILTER=2 → outputs stay 0 after the first cycle, then link_up=1, link_speed=2'b10, full_duplex=1. A dv=0/er=1 glitch between the samples does not reset the count.
- Speed 01→00 mid-DATA → error strobe (dv=1, er=1, rxd=0), then the end strobe, then IDLE. rst asserted mid-frame → all outputs 0 the next cycle with no error strobe.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared constants and types for the RGMII receive path: speed codes, preamble/SFD
// nibbles, receive state encoding and the output byte record.
package rgmii_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam logic [3:0] NIB_PREAMBLE = 4'h5;
    localparam logic [3:0] NIB_SFD      = 4'hD;

    localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE_ENC = 2'd1;
    localparam logic [1:0] ST_DATA_ENC     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_PREAMBLE = ST_PREAMBLE_ENC,
        ST_DATA     = ST_DATA_ENC
    } rx_state_e;

    typedef struct packed {
        logic [7:0] rxd;
        logic       dv;
        logic       er;
    } rx_byte_t;

    // Also used as the end-of-frame marker: a strobe carrying dv=0, er=0.
    localparam rx_byte_t RX_BYTE_NONE = '{rxd: 8'h00, dv: 1'b0, er: 1'b0};
    localparam rx_byte_t RX_BYTE_ERR  = '{rxd: 8'h00, dv: 1'b1, er: 1'b1};

    // Both 2'b10 and 2'b11 select gigabit operation.
    function automatic logic is_gig(input logic [1:0] spd);
        return (spd & SPEED_1000) == SPEED_1000;
    endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// RGMII in-band link status decoder: a debounce filter that only lets a status word
// through after STATUS_FILTER consecutive identical inter-frame samples.
module rgmii_inband_status #(
    parameter int STATUS_FILTER = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [3:0] sample,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex
);

    localparam logic [3:0] FILT = 4'(STATUS_FILTER);

    logic [3:0] prev_q, prev_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] stat_q, stat_d;

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        stat_d = stat_q;
        if (sample_en) begin
            prev_d = sample;
            // cnt_q==0 means nothing sampled since reset, so the first sample starts a run.
            if (cnt_q != 4'd0 && sample == prev_q) begin
                cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
            end
            if (cnt_d >= FILT) begin
                stat_d = sample;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 4'd0;
            cnt_q  <= 4'd0;
            stat_q <= 4'd0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            stat_q <= stat_d;
        end
    end

    assign link_up     = stat_q[0];
    assign link_speed  = stat_q[2:1];
    assign full_duplex = stat_q[3];

endmodule

// File: rtl/gmii_rx_speed_adapter.sv
// Receive speed adapter behind the RGMII DDR input stage: nibble-to-byte packing with
// SFD alignment at 10/100, registered pass-through at 1000, plus in-band status decode.
module gmii_rx_speed_adapter
    import rgmii_pkg::*;
#(
    parameter int STATUS_FILTER = 2,
    parameter bit ENABLE_INBAND = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic [7:0] out_rxd,
    output logic       out_rx_dv,
    output logic       out_rx_er,
    output logic       out_clk_en,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex
);

    rx_state_e  state_q, state_d;
    logic [1:0] speed_q;
    logic       phase_q, phase_d;     // 1 = low nibble held, waiting for the high one
    logic [3:0] low_q, low_d;
    logic       low_er_q, low_er_d;
    logic [3:0] prev_q, prev_d;
    logic       end_pend_q, end_pend_d;
    rx_byte_t   out_q, out_d;
    logic       clk_en_q, clk_en_d;

    logic [3:0] nib;
    logic       gig;
    logic       spd_chg;

    assign nib     = gmii_rxd[3:0];
    assign gig     = is_gig(speed);
    assign spd_chg = (speed != speed_q);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        low_d      = low_q;
        low_er_d   = low_er_q;
        prev_d     = prev_q;
        end_pend_d = 1'b0;
        out_d      = out_q;
        clk_en_d   = 1'b0;

        if (gig) begin
            state_d  = ST_IDLE;
            phase_d  = 1'b0;
            out_d    = '{rxd: gmii_rxd, dv: gmii_rx_dv, er: gmii_rx_er};
            clk_en_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gmii_rx_dv) begin
                        state_d = ST_PREAMBLE;
                        prev_d  = nib;
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_d = ST_IDLE;
                    end else begin
                        prev_d = nib;
                        if (nib == NIB_SFD && prev_q == NIB_PREAMBLE) begin
                            out_d    = '{rxd: {NIB_SFD, NIB_PREAMBLE}, dv: 1'b1, er: gmii_rx_er};
                            clk_en_d = 1'b1;
                            state_d  = ST_DATA;
                            phase_d  = 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (!gmii_rx_dv) begin
                        state_d  = ST_IDLE;
                        phase_d  = 1'b0;
                        clk_en_d = 1'b1;
                        if (phase_q) begin
                            // Odd nibble count: flush the orphan nibble as a bad byte.
                            out_d      = '{rxd: {4'h0, low_q}, dv: 1'b1, er: 1'b1};
                            end_pend_d = 1'b1;
                        end else begin
                            out_d = RX_BYTE_NONE;
                        end
                    end else if (!phase_q) begin
                        low_d    = nib;
                        low_er_d = gmii_rx_er;
                        phase_d  = 1'b1;
                    end else begin
                        out_d    = '{rxd: {nib, low_q}, dv: 1'b1, er: gmii_rx_er | low_er_q};
                        clk_en_d = 1'b1;
                        phase_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                end
            endcase
        end

        // The FSM is always in IDLE while an end marker is pending, so nothing collides.
        if (end_pend_q) begin
            out_d    = RX_BYTE_NONE;
            clk_en_d = 1'b1;
        end

        if (spd_chg) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
            if (state_q == ST_DATA) begin
                out_d      = RX_BYTE_ERR;
                clk_en_d   = 1'b1;
                end_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            speed_q    <= speed;
            phase_q    <= 1'b0;
            low_q      <= 4'd0;
            low_er_q   <= 1'b0;
            prev_q     <= 4'd0;
            end_pend_q <= 1'b0;
            out_q      <= RX_BYTE_NONE;
            clk_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed;
            phase_q    <= phase_d;
            low_q      <= low_d;
            low_er_q   <= low_er_d;
            prev_q     <= prev_d;
            end_pend_q <= end_pend_d;
            out_q      <= out_d;
            clk_en_q   <= clk_en_d;
        end
    end

    assign out_rxd    = out_q.rxd;
    assign out_rx_dv  = out_q.dv;
    assign out_rx_er  = out_q.er;
    assign out_clk_en = clk_en_q;

    generate
        if (ENABLE_INBAND) begin : g_inband
            rgmii_inband_status #(
                .STATUS_FILTER(STATUS_FILTER)
            ) u_status (
                .clk        (clk),
                .rst        (rst),
                .sample_en  (!gmii_rx_dv && !gmii_rx_er),
                .sample     (gmii_rxd[3:0]),
                .link_up    (link_up),
                .link_speed (link_speed),
                .full_duplex(full_duplex)
            );
        end else begin : g_no_inband
            assign link_up     = 1'b0;
            assign link_speed  = 2'b00;
            assign full_duplex = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_gmii_rx_speed_adapter.sv
// Directed-vector bench for gmii_rx_speed_adapter: a table of per-cycle inputs and
// expected strobes, followed by hand sequences for in-band status and mid-frame reset.
module tb_gmii_rx_speed_adapter;
    import rgmii_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] out_rxd;
    logic       out_rx_dv;
    logic       out_rx_er;
    logic       out_clk_en;
    logic       link_up;
    logic [1:0] link_speed;
    logic       full_duplex;

    gmii_rx_speed_adapter #(
        .STATUS_FILTER(2),
        .ENABLE_INBAND(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .speed      (speed),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .out_rxd    (out_rxd),
        .out_rx_dv  (out_rx_dv),
        .out_rx_er  (out_rx_er),
        .out_clk_en (out_clk_en),
        .link_up    (link_up),
        .link_speed (link_speed),
        .full_duplex(full_duplex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] spd;
        logic [7:0] d;
        logic       dv;
        logic       er;
        logic       en;      // a strobe is expected after this cycle
        logic       odv;
        logic       oer;
        logic [7:0] ord;
        logic       ck_rxd;  // rxd is don't-care on end-of-frame markers
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic       ex_dv, ex_er, ex_ck;
    logic [7:0] ex_rxd;

    task automatic nv(input logic [1:0] s, input logic [7:0] d, input logic dv, input logic er);
        vecs.push_back('{spd: s, d: d, dv: dv, er: er, en: 1'b0, odv: 1'b0, oer: 1'b0,
                         ord: 8'h00, ck_rxd: 1'b0});
    endtask

    task automatic sv(input logic [1:0] s, input logic [7:0] d, input logic dv, input logic er,
                      input logic odv, input logic oer, input logic [7:0] ord, input logic ck);
        vecs.push_back('{spd: s, d: d, dv: dv, er: er, en: 1'b1, odv: odv, oer: oer,
                         ord: ord, ck_rxd: ck});
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %02h, expected %02h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] d, input logic dv, input logic er);
        speed      = s;
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string name, input int idx, input logic lu,
                              input logic [1:0] ls, input logic fd);
        chk({name, "_link_up"}, idx, {7'd0, link_up}, {7'd0, lu});
        chk({name, "_link_speed"}, idx, {6'd0, link_speed}, {6'd0, ls});
        chk({name, "_duplex"}, idx, {7'd0, full_duplex}, {7'd0, fd});
    endtask

    initial begin
        // 1000M: straight registered pass-through, strobe every cycle.
        for (int i = 0; i < 7; i++) sv(SPEED_1000, 8'h55, 1, 0, 1, 0, 8'h55, 1);
        sv(SPEED_1000, 8'hD5, 1, 0, 1, 0, 8'hD5, 1);
        for (int i = 1; i <= 64; i++) sv(SPEED_1000, 8'(i), 1, 0, 1, 0, 8'(i), 1);
        sv(SPEED_1000, 8'hFF, 1, 1, 1, 1, 8'hFF, 1);
        sv(SPEED_1000, 8'h00, 0, 0, 0, 0, 8'h00, 1);
        // 100M even frame; nothing before the SFD.
        nv(SPEED_100, 8'h00, 0, 0);
        for (int i = 0; i < 15; i++) nv(SPEED_100, 8'h05, 1, 0);
        sv(SPEED_100, 8'h0D, 1, 0, 1, 0, 8'hD5, 1);
        nv(SPEED_100, 8'h01, 1, 0);
        sv(SPEED_100, 8'h00, 1, 0, 1, 0, 8'h01, 1);
        nv(SPEED_100, 8'h02, 1, 0);
        sv(SPEED_100, 8'h00, 1, 0, 1, 0, 8'h02, 1);
        sv(SPEED_100, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        nv(SPEED_100, 8'h00, 0, 0);
        // 100M: error on the high nibble of the 2nd data byte only.
        nv(SPEED_100, 8'h05, 1, 0);
        nv(SPEED_100, 8'h05, 1, 0);
        sv(SPEED_100, 8'h0D, 1, 0, 1, 0, 8'hD5, 1);
        nv(SPEED_100, 8'h03, 1, 0);
        sv(SPEED_100, 8'h00, 1, 0, 1, 0, 8'h03, 1);
        nv(SPEED_100, 8'h04, 1, 0);
        sv(SPEED_100, 8'h00, 1, 1, 1, 1, 8'h04, 1);
        nv(SPEED_100, 8'h05, 1, 0);
        sv(SPEED_100, 8'h00, 1, 0, 1, 0, 8'h05, 1);
        sv(SPEED_100, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        nv(SPEED_100, 8'h00, 0, 0);
        // 10M odd frame: orphan nibble flushed with er, then the end marker.
        nv(SPEED_10, 8'h00, 0, 0);
        nv(SPEED_10, 8'h05, 1, 0);
        nv(SPEED_10, 8'h05, 1, 0);
        sv(SPEED_10, 8'h0D, 1, 0, 1, 0, 8'hD5, 1);
        nv(SPEED_10, 8'h0A, 1, 0);
        sv(SPEED_10, 8'h0B, 1, 0, 1, 0, 8'hBA, 1);
        nv(SPEED_10, 8'h0C, 1, 0);
        sv(SPEED_10, 8'h00, 0, 0, 1, 1, 8'h0C, 1);
        sv(SPEED_10, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        nv(SPEED_10, 8'h00, 0, 0);
        // Speed 01 -> 00 in DATA with a nibble pending: error strobe, end marker, idle.
        nv(SPEED_100, 8'h00, 0, 0);
        nv(SPEED_100, 8'h05, 1, 0);
        nv(SPEED_100, 8'h05, 1, 0);
        sv(SPEED_100, 8'h0D, 1, 0, 1, 0, 8'hD5, 1);
        nv(SPEED_100, 8'h01, 1, 0);
        sv(SPEED_100, 8'h00, 1, 0, 1, 0, 8'h01, 1);
        nv(SPEED_100, 8'h02, 1, 0);
        sv(SPEED_10, 8'h00, 1, 0, 1, 1, 8'h00, 1);
        sv(SPEED_10, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        nv(SPEED_10, 8'h00, 0, 0);
        nv(SPEED_10, 8'h00, 0, 0);

        // Reset state.
        rst = 1'b1;
        drive(SPEED_1000, 8'h00, 0, 0);
        drive(SPEED_1000, 8'h00, 0, 0);
        chk("rst_clk_en", 0, {7'd0, out_clk_en}, 8'h00);
        chk("rst_rxd", 0, out_rxd, 8'h00);
        chk("rst_dv_er", 0, {6'd0, out_rx_dv, out_rx_er}, 8'h00);
        chk_status("rst", 0, 1'b0, 2'b00, 1'b0);
        rst = 1'b0;

        ex_dv = 1'b0; ex_er = 1'b0; ex_rxd = 8'h00; ex_ck = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].spd, vecs[i].d, vecs[i].dv, vecs[i].er);
            if (vecs[i].en) begin
                ex_dv  = vecs[i].odv;
                ex_er  = vecs[i].oer;
                ex_rxd = vecs[i].ord;
                ex_ck  = vecs[i].ck_rxd;
            end
            chk("clk_en", i, {7'd0, out_clk_en}, {7'd0, vecs[i].en});
            chk("rx_dv", i, {7'd0, out_rx_dv}, {7'd0, ex_dv});
            chk("rx_er", i, {7'd0, out_rx_er}, {7'd0, ex_er});
            if (ex_ck) chk("rxd", i, out_rxd, ex_rxd);
        end

        // In-band status, filter of 2; a dv=0/er=1 sample sits between the two matches.
        chk_status("st_idle0", 0, 1'b0, 2'b00, 1'b0);
        drive(SPEED_10, 8'h0D, 0, 0);
        chk_status("st_first", 1, 1'b0, 2'b00, 1'b0);
        drive(SPEED_10, 8'h00, 0, 1);
        chk_status("st_glitch", 2, 1'b0, 2'b00, 1'b0);
        drive(SPEED_10, 8'h0D, 0, 0);
        chk_status("st_second", 3, 1'b1, 2'b10, 1'b1);
        drive(SPEED_10, 8'h00, 0, 0);
        chk_status("st_single_diff", 4, 1'b1, 2'b10, 1'b1);
        drive(SPEED_10, 8'h00, 0, 0);
        chk_status("st_cleared", 5, 1'b0, 2'b00, 1'b0);
        drive(SPEED_10, 8'h0D, 0, 0);
        drive(SPEED_10, 8'h0D, 0, 0);
        chk_status("st_set_again", 6, 1'b1, 2'b10, 1'b1);

        // Reset in the middle of a 10M frame: everything clears, no error or end strobe.
        drive(SPEED_10, 8'h05, 1, 0);
        drive(SPEED_10, 8'h05, 1, 0);
        drive(SPEED_10, 8'h0D, 1, 0);
        chk("mr_sfd", 0, out_rxd, 8'hD5);
        drive(SPEED_10, 8'h01, 1, 0);
        rst = 1'b1;
        drive(SPEED_10, 8'h00, 1, 0);
        rst = 1'b0;
        chk("mr_clk_en", 1, {7'd0, out_clk_en}, 8'h00);
        chk("mr_rxd", 1, out_rxd, 8'h00);
        chk("mr_dv_er", 1, {6'd0, out_rx_dv, out_rx_er}, 8'h00);
        chk_status("mr", 1, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(SPEED_10, 8'h00, 0, 0);
            chk("mr_quiet_clk_en", 2 + i, {7'd0, out_clk_en}, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
